// File: rtl/pc_sequencer.sv
// pc_sequencer: next fetch address controller with post-reset boot hold, redirect flush window and halt.
module pc_sequencer #(
    parameter int                    ADDR_WIDTH   = 11,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    FLUSH_CYCLES = 1
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  stall_i,
    input  logic                  branch_taken_i,
    input  logic [ADDR_WIDTH-1:0] branch_target_i,
    input  logic                  jump_i,
    input  logic [ADDR_WIDTH-1:0] jump_target_i,
    input  logic                  halt_i,
    input  logic                  resume_i,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic [ADDR_WIDTH-1:0] pc_next_o,
    output logic                  fetch_valid_o,
    output logic                  flush_o,
    output logic                  halted_o,
    output logic                  wrapped_o
);
    typedef enum logic [1:0] {BOOT, RUN, FLUSH, HALTED} state_e;
    localparam logic [2:0] CNT_LAST = 3'(FLUSH_CYCLES - 1);
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  wrapped_q, wrapped_d;
    logic                  redirect;
    logic [ADDR_WIDTH-1:0] target;
    assign redirect = branch_taken_i | jump_i;
    assign target   = branch_taken_i ? branch_target_i : jump_target_i;
    // Redirects behave identically in RUN and FLUSH: load target and (re)start the window.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        wrapped_d = wrapped_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (redirect) begin
                    pc_d    = target;
                    cnt_d   = '0;
                    state_d = FLUSH;
                end else if (halt_i) begin
                    state_d = HALTED;
                end else if (!stall_i) begin
                    pc_d      = pc_q + 1'b1;
                    wrapped_d = wrapped_q | (&pc_q);
                end
            end
            FLUSH: begin
                if (redirect) begin
                    pc_d  = target;
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            HALTED: state_d = resume_i ? RUN : HALTED;
            default: state_d = BOOT;
        endcase
    end
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= BOOT;
            pc_q      <= RESET_VECTOR;
            cnt_q     <= '0;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            wrapped_q <= wrapped_d;
        end
    end
    assign pc_o          = pc_q;
    assign pc_next_o     = reset_i ? RESET_VECTOR : pc_d;
    assign fetch_valid_o = state_q == RUN;
    assign flush_o       = state_q == FLUSH;
    assign halted_o      = state_q == HALTED;
    assign wrapped_o     = wrapped_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed table plus randomized run against a countdown-based reference model.
module tb_pc_sequencer;
    localparam int FC = 2;
    localparam int RV = 0;
    logic        clock = 1'b0;
    logic        reset, stall, branch_taken, jump, halt, resume;
    logic [10:0] branch_target, jump_target;
    logic [10:0] pc, pc_next;
    logic        fetch_valid, flush, halted, wrapped;
    int checks = 0;
    int errors = 0;
    bit m_boot = 1'b1;
    bit m_hlt  = 1'b0;
    bit m_w    = 1'b0;
    int m_left = 0;
    int m_pc   = RV;

    pc_sequencer #(.ADDR_WIDTH(11), .RESET_VECTOR(11'(RV)), .FLUSH_CYCLES(FC)) dut (
        .clock_i(clock), .reset_i(reset), .stall_i(stall),
        .branch_taken_i(branch_taken), .branch_target_i(branch_target),
        .jump_i(jump), .jump_target_i(jump_target),
        .halt_i(halt), .resume_i(resume),
        .pc_o(pc), .pc_next_o(pc_next), .fetch_valid_o(fetch_valid),
        .flush_o(flush), .halted_o(halted), .wrapped_o(wrapped)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic rst, st, br; logic [10:0] bt; logic jp; logic [10:0] jt; logic hl, rsm;
        logic [10:0] pc; logic fv, fl, h, w;
    } vec_t;
    vec_t v[$];

    function automatic vec_t mk(input logic rst, st, br, input logic [10:0] bt, input logic jp,
                                input logic [10:0] jt, input logic hl, rsm,
                                input logic [10:0] epc, input logic fv, fl, h, w);
        vec_t r;
        r.rst = rst; r.st = st; r.br = br; r.bt = bt; r.jp = jp; r.jt = jt; r.hl = hl; r.rsm = rsm;
        r.pc = epc; r.fv = fv; r.fl = fl; r.h = h; r.w = w;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, predict with the model, check pc_next, clock, check registered outputs.
    task automatic cyc(input logic rs, st, br, input logic [10:0] bt, input logic jp,
                       input logic [10:0] jt, input logic hl, rsm);
        int n_pc, n_left;
        bit n_boot, n_hlt, n_w;
        @(negedge clock);
        reset = rs; stall = st; branch_taken = br; branch_target = bt;
        jump = jp; jump_target = jt; halt = hl; resume = rsm;
        n_pc = m_pc; n_left = m_left; n_boot = m_boot; n_hlt = m_hlt; n_w = m_w;
        if (rs) begin
            n_boot = 1'b1; n_left = 0; n_hlt = 1'b0; n_pc = RV; n_w = 1'b0;
        end else if (m_boot) begin
            n_boot = 1'b0;
        end else if (m_hlt) begin
            if (rsm) n_hlt = 1'b0;
        end else if (br || jp) begin
            n_pc = br ? int'(bt) : int'(jt);
            n_left = FC;
        end else if (m_left > 0) begin
            n_left = m_left - 1;
        end else if (hl) begin
            n_hlt = 1'b1;
        end else if (!st) begin
            n_pc = (m_pc + 1) % 2048;
            if (n_pc == 0) n_w = 1'b1;
        end
        #1;
        chk("pc_next", pc_next, n_pc);
        @(posedge clock);
        m_pc = n_pc; m_left = n_left; m_boot = n_boot; m_hlt = n_hlt; m_w = n_w;
        #1;
        chk("pc", pc, m_pc);
        chk("fetch_valid", fetch_valid, !m_boot && !m_hlt && m_left == 0);
        chk("flush", flush, m_left > 0);
        chk("halted", halted, m_hlt);
        chk("wrapped", wrapped, m_w);
    endtask

    initial begin
        logic [10:0] bt, jt;
        // rst st br bt jp jt hl rsm | pc fv fl h w
        v.push_back(mk(1, 0, 0, 0,      0, 0,      0, 0, 11'h000, 0, 0, 0, 0));
        v.push_back(mk(0, 0, 0, 0,      0, 0,      0, 0, 11'h000, 1, 0, 0, 0));
        v.push_back(mk(0, 0, 0, 0,      0, 0,      0, 0, 11'h001, 1, 0, 0, 0));
        v.push_back(mk(0, 0, 0, 0,      0, 0,      0, 0, 11'h002, 1, 0, 0, 0));
        v.push_back(mk(0, 0, 0, 0,      1, 11'h010, 0, 0, 11'h010, 0, 1, 0, 0));
        v.push_back(mk(0, 0, 0, 0,      0, 0,      0, 0, 11'h010, 0, 1, 0, 0));
        v.push_back(mk(0, 0, 0, 0,      0, 0,      0, 0, 11'h010, 1, 0, 0, 0));
        v.push_back(mk(0, 0, 1, 11'h200, 0, 0,      0, 0, 11'h200, 0, 1, 0, 0));
        v.push_back(mk(0, 0, 0, 0,      0, 0,      0, 0, 11'h200, 0, 1, 0, 0));
        v.push_back(mk(0, 0, 0, 0,      0, 0,      0, 0, 11'h200, 1, 0, 0, 0));
        v.push_back(mk(0, 0, 0, 0,      0, 0,      0, 0, 11'h201, 1, 0, 0, 0));
        v.push_back(mk(0, 0, 1, 11'h7FE, 0, 0,      0, 0, 11'h7FE, 0, 1, 0, 0));
        v.push_back(mk(0, 0, 0, 0,      0, 0,      0, 0, 11'h7FE, 0, 1, 0, 0));
        v.push_back(mk(0, 0, 0, 0,      0, 0,      0, 0, 11'h7FE, 1, 0, 0, 0));
        v.push_back(mk(0, 0, 0, 0,      0, 0,      0, 0, 11'h7FF, 1, 0, 0, 0));
        v.push_back(mk(0, 0, 0, 0,      0, 0,      0, 0, 11'h000, 1, 0, 0, 1));
        v.push_back(mk(0, 0, 0, 0,      1, 11'h045, 0, 0, 11'h045, 0, 1, 0, 1));
        v.push_back(mk(0, 0, 0, 0,      0, 0,      0, 0, 11'h045, 0, 1, 0, 1));
        v.push_back(mk(0, 0, 0, 0,      0, 0,      0, 0, 11'h045, 1, 0, 0, 1));
        v.push_back(mk(0, 1, 0, 0,      0, 0,      0, 0, 11'h045, 1, 0, 0, 1));
        v.push_back(mk(0, 1, 0, 0,      0, 0,      0, 0, 11'h045, 1, 0, 0, 1));
        v.push_back(mk(0, 1, 0, 0,      0, 0,      0, 0, 11'h045, 1, 0, 0, 1));
        v.push_back(mk(0, 0, 0, 0,      0, 0,      0, 0, 11'h046, 1, 0, 0, 1));
        v.push_back(mk(0, 1, 1, 11'h100, 1, 11'h300, 0, 0, 11'h100, 0, 1, 0, 1));
        v.push_back(mk(0, 0, 0, 0,      0, 0,      0, 0, 11'h100, 0, 1, 0, 1));
        v.push_back(mk(0, 0, 0, 0,      0, 0,      0, 0, 11'h100, 1, 0, 0, 1));
        v.push_back(mk(0, 0, 0, 0,      1, 11'h020, 0, 0, 11'h020, 0, 1, 0, 1));
        v.push_back(mk(0, 0, 0, 0,      0, 0,      0, 0, 11'h020, 0, 1, 0, 1));
        v.push_back(mk(0, 0, 0, 0,      0, 0,      0, 0, 11'h020, 1, 0, 0, 1));
        v.push_back(mk(0, 0, 0, 0,      0, 0,      1, 0, 11'h020, 0, 0, 1, 1));
        v.push_back(mk(0, 0, 0, 0,      0, 0,      1, 0, 11'h020, 0, 0, 1, 1));
        v.push_back(mk(0, 0, 0, 0,      1, 11'h300, 1, 0, 11'h020, 0, 0, 1, 1));
        v.push_back(mk(0, 0, 0, 0,      0, 0,      1, 0, 11'h020, 0, 0, 1, 1));
        v.push_back(mk(0, 0, 0, 0,      0, 0,      0, 0, 11'h020, 0, 0, 1, 1));
        v.push_back(mk(0, 0, 0, 0,      0, 0,      0, 1, 11'h020, 1, 0, 0, 1));
        v.push_back(mk(0, 0, 0, 0,      0, 0,      0, 0, 11'h021, 1, 0, 0, 1));
        v.push_back(mk(0, 0, 1, 11'h150, 0, 0,      0, 0, 11'h150, 0, 1, 0, 1));
        v.push_back(mk(1, 0, 0, 0,      0, 0,      0, 0, 11'h000, 0, 0, 0, 0));
        v.push_back(mk(0, 0, 0, 0,      0, 0,      0, 0, 11'h000, 1, 0, 0, 0));
        v.push_back(mk(0, 0, 0, 0,      0, 0,      1, 0, 11'h000, 0, 0, 1, 0));
        v.push_back(mk(1, 0, 0, 0,      0, 0,      0, 0, 11'h000, 0, 0, 0, 0));
        v.push_back(mk(0, 0, 0, 0,      0, 0,      0, 0, 11'h000, 1, 0, 0, 0));
        v.push_back(mk(0, 0, 1, 11'h050, 0, 0,      1, 0, 11'h050, 0, 1, 0, 0));
        v.push_back(mk(0, 0, 0, 0,      0, 0,      1, 0, 11'h050, 0, 1, 0, 0));
        v.push_back(mk(0, 0, 0, 0,      0, 0,      1, 0, 11'h050, 1, 0, 0, 0));
        v.push_back(mk(0, 0, 0, 0,      0, 0,      1, 0, 11'h050, 0, 0, 1, 0));
        v.push_back(mk(0, 0, 0, 0,      0, 0,      0, 1, 11'h050, 1, 0, 0, 0));
        v.push_back(mk(0, 0, 0, 0,      1, 11'h060, 0, 0, 11'h060, 0, 1, 0, 0));
        v.push_back(mk(0, 0, 1, 11'h070, 0, 0,      0, 0, 11'h070, 0, 1, 0, 0));
        v.push_back(mk(0, 0, 0, 0,      0, 0,      0, 0, 11'h070, 0, 1, 0, 0));
        v.push_back(mk(0, 0, 0, 0,      0, 0,      0, 0, 11'h070, 1, 0, 0, 0));
        foreach (v[i]) begin
            cyc(v[i].rst, v[i].st, v[i].br, v[i].bt, v[i].jp, v[i].jt, v[i].hl, v[i].rsm);
            chk($sformatf("row%0d_pc", i), pc, v[i].pc);
            chk($sformatf("row%0d_fv", i), fetch_valid, v[i].fv);
            chk($sformatf("row%0d_flush", i), flush, v[i].fl);
            chk($sformatf("row%0d_halted", i), halted, v[i].h);
            chk($sformatf("row%0d_wrapped", i), wrapped, v[i].w);
        end
        for (int i = 0; i < 3000; i++) begin
            bt = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(2032, 2047)) : 11'($urandom);
            jt = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(2032, 2047)) : 11'($urandom);
            cyc($urandom_range(0, 149) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, bt,
                $urandom_range(0, 9) == 0, jt, $urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
